// File: rtl/watch_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : watch_mode_scheduler
// Brief    : Watch/stopwatch/cook-timer mode controller with alarm preemption,
//            button routing and FND value mux. Optional macro AUTO_RETURN_EN
//            adds an inactivity return to watch mode.
// Revision : 1.0 - initial release
// ============================================================================
module watch_mode_scheduler #(
    parameter int TICK_DIV = 100000,
    parameter int IDLE_MS  = 30000,
    parameter int BLINK_MS = 250
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        btn_mode,
    input  logic [3:0]  btn_pe,
    input  logic [15:0] watch_value,
    input  logic [15:0] stop_value,
    input  logic [15:0] cook_value,
    input  logic        cook_alarm,
    input  logic        stopw_run,
    output logic [2:0]  mode,
    output logic        alarm_active,
    output logic        alarm_ack,
    output logic [3:0]  watch_btn,
    output logic [2:0]  stopw_btn,
    output logic [2:0]  cook_btn,
    output logic [15:0] value,
    output logic        fnd_blank
);

    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BLINK_W = $clog2(BLINK_MS + 1);

    localparam logic [TICK_W-1:0]  c_TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [BLINK_W-1:0] c_BLINK_LAST = BLINK_W'(BLINK_MS - 1);
    localparam logic [2:0]         c_MODE_WATCH = 3'b001;
    localparam logic [2:0]         c_MODE_STOPW = 3'b010;
    localparam logic [2:0]         c_MODE_COOK  = 3'b100;

    typedef enum logic [1:0] {
        S_WATCH = 2'd0,
        S_STOPW = 2'd1,
        S_COOK  = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    state_t               r_state;
    state_t               r_saved_state;
    state_t               w_next_state;
    logic                 r_cook_alarm_d;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [BLINK_W-1:0]   r_blink_cnt;
    logic [2:0]           r_mode;
    logic                 r_alarm_active;
    logic                 r_alarm_ack;
    logic [3:0]           r_watch_btn;
    logic [2:0]           r_stopw_btn;
    logic [2:0]           r_cook_btn;
    logic [15:0]          r_value;
    logic                 r_fnd_blank;

    logic w_tick;
    logic w_any_btn;
    logic w_alarm_rise;
    logic w_timeout;

    assign w_tick       = (r_tick_cnt == c_TICK_LAST);
    assign w_any_btn    = btn_mode | (|btn_pe);
    assign w_alarm_rise = cook_alarm & ~r_cook_alarm_d;

`ifdef AUTO_RETURN_EN
    localparam int IDLE_W = $clog2(IDLE_MS + 1);
    localparam logic [IDLE_W-1:0] c_IDLE_LIMIT = IDLE_W'(IDLE_MS);

    logic [IDLE_W-1:0] r_idle_cnt;
    logic              w_idle_state;

    assign w_idle_state = (r_state == S_STOPW) || (r_state == S_COOK);
    // A function-button press in the expiry cycle keeps the user in the app.
    assign w_timeout    = w_idle_state && (r_idle_cnt == c_IDLE_LIMIT) && !(|btn_pe);

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_idle_cnt <= '0;
        end else if ((w_next_state != r_state) || w_any_btn || !w_idle_state ||
                     ((r_state == S_STOPW) && stopw_run)) begin
            r_idle_cnt <= '0;
        end else if (w_tick && (r_idle_cnt != c_IDLE_LIMIT)) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    logic w_unused_stopw_run;

    assign w_unused_stopw_run = stopw_run;
    assign w_timeout          = 1'b0;
`endif

    // Priority: alarm edge, then mode button, then inactivity timeout.
    always_comb begin
        w_next_state = r_state;
        if (r_state == S_ALARM) begin
            if (w_any_btn) begin
                w_next_state = r_saved_state;
            end
        end else if (w_alarm_rise) begin
            w_next_state = S_ALARM;
        end else if (btn_mode) begin
            case (r_state)
                S_WATCH: w_next_state = S_STOPW;
                S_STOPW: w_next_state = S_COOK;
                default: w_next_state = S_WATCH;
            endcase
        end else if (w_timeout) begin
            w_next_state = S_WATCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_state        <= S_WATCH;
            r_saved_state  <= S_WATCH;
            r_cook_alarm_d <= 1'b0;
            r_tick_cnt     <= '0;
            r_blink_cnt    <= '0;
            r_mode         <= c_MODE_WATCH;
            r_alarm_active <= 1'b0;
            r_alarm_ack    <= 1'b0;
            r_watch_btn    <= '0;
            r_stopw_btn    <= '0;
            r_cook_btn     <= '0;
            r_value        <= '0;
            r_fnd_blank    <= 1'b0;
        end else begin
            r_cook_alarm_d <= cook_alarm;
            r_tick_cnt     <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_state        <= w_next_state;
            r_alarm_active <= (w_next_state == S_ALARM);

            case (w_next_state)
                S_WATCH: r_mode <= c_MODE_WATCH;
                S_STOPW: r_mode <= c_MODE_STOPW;
                default: r_mode <= c_MODE_COOK;
            endcase

            case (r_state)
                S_WATCH: r_value <= watch_value;
                S_STOPW: r_value <= stop_value;
                default: r_value <= cook_value;
            endcase

            r_watch_btn <= '0;
            r_stopw_btn <= '0;
            r_cook_btn  <= '0;
            r_alarm_ack <= 1'b0;
            case (r_state)
                S_WATCH: if (!w_alarm_rise) r_watch_btn <= btn_pe;
                S_STOPW: if (!w_alarm_rise) r_stopw_btn <= btn_pe[2:0];
                S_COOK:  if (!w_alarm_rise) r_cook_btn  <= btn_pe[2:0];
                default: r_alarm_ack <= w_any_btn;
            endcase

            if (r_state != S_ALARM) begin
                if (w_alarm_rise) begin
                    r_saved_state <= r_state;
                    r_blink_cnt   <= '0;
                end
                r_fnd_blank <= 1'b0;
            end else if (w_any_btn) begin
                r_fnd_blank <= 1'b0;
            end else if (w_tick) begin
                if (r_blink_cnt == c_BLINK_LAST) begin
                    r_blink_cnt <= '0;
                    r_fnd_blank <= ~r_fnd_blank;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    assign mode         = r_mode;
    assign alarm_active = r_alarm_active;
    assign alarm_ack    = r_alarm_ack;
    assign watch_btn    = r_watch_btn;
    assign stopw_btn    = r_stopw_btn;
    assign cook_btn     = r_cook_btn;
    assign value        = r_value;
    assign fnd_blank    = r_fnd_blank;

endmodule
`default_nettype wire

// File: tb/tb_watch_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_watch_mode_scheduler
// Brief    : Directed self-checking bench for watch_mode_scheduler
//            (TICK_DIV=10, IDLE_MS=20, BLINK_MS=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_watch_mode_scheduler;

    logic        clk;
    logic        reset_p;
    logic        btn_mode;
    logic [3:0]  btn_pe;
    logic [15:0] watch_value;
    logic [15:0] stop_value;
    logic [15:0] cook_value;
    logic        cook_alarm;
    logic        stopw_run;
    logic [2:0]  mode;
    logic        alarm_active;
    logic        alarm_ack;
    logic [3:0]  watch_btn;
    logic [2:0]  stopw_btn;
    logic [2:0]  cook_btn;
    logic [15:0] value;
    logic        fnd_blank;

    int n_vec = 0;
    int n_err = 0;

    watch_mode_scheduler #(
        .TICK_DIV (10),
        .IDLE_MS  (20),
        .BLINK_MS (3)
    ) u_dut (
        .clk          (clk),
        .reset_p      (reset_p),
        .btn_mode     (btn_mode),
        .btn_pe       (btn_pe),
        .watch_value  (watch_value),
        .stop_value   (stop_value),
        .cook_value   (cook_value),
        .cook_alarm   (cook_alarm),
        .stopw_run    (stopw_run),
        .mode         (mode),
        .alarm_active (alarm_active),
        .alarm_ack    (alarm_ack),
        .watch_btn    (watch_btn),
        .stopw_btn    (stopw_btn),
        .cook_btn     (cook_btn),
        .value        (value),
        .fnd_blank    (fnd_blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
    endtask

    task automatic press_pe(input logic [3:0] pat);
        btn_pe = pat;
        tick();
        btn_pe = 4'b0000;
    endtask

    task automatic check_routes(input string tag, input logic [3:0] w, input logic [2:0] s,
                                input logic [2:0] c);
        check_val({tag, "_watch_btn"}, 32'(watch_btn), 32'(w));
        check_val({tag, "_stopw_btn"}, 32'(stopw_btn), 32'(s));
        check_val({tag, "_cook_btn"},  32'(cook_btn),  32'(c));
    endtask

    // Waits for fnd_blank to reach target; returns cycles taken (limit+1 on timeout).
    task automatic wait_blank(input logic target, input int limit, output int cycles);
        cycles = 0;
        while (fnd_blank !== target && cycles <= limit) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        int n;
        reset_p     = 1'b1;
        btn_mode    = 1'b0;
        btn_pe      = 4'b0000;
        watch_value = 16'h1111;
        stop_value  = 16'h2222;
        cook_value  = 16'h3333;
        cook_alarm  = 1'b0;
        stopw_run   = 1'b0;
        repeat (3) tick();
        reset_p = 1'b0;

        // Reset state
        check_val("rst_mode",  32'(mode), 32'h1);
        check_val("rst_value", 32'(value), 32'h0);
        check_val("rst_alarm", 32'(alarm_active), 32'h0);
        check_val("rst_ack",   32'(alarm_ack), 32'h0);
        check_val("rst_blank", 32'(fnd_blank), 32'h0);
        check_routes("rst", 4'h0, 3'h0, 3'h0);
        tick();
        check_val("watch_value", 32'(value), 32'h1111);

        // Watch routing, then mode cycling
        press_pe(4'b1010);
        check_routes("watch_rt", 4'b1010, 3'h0, 3'h0);
        tick();
        check_routes("watch_rt_end", 4'h0, 3'h0, 3'h0);

        btn_mode = 1'b1;
        btn_pe   = 4'b0001;
        tick();
        btn_mode = 1'b0;
        btn_pe   = 4'b0000;
        check_val("mode_stopw", 32'(mode), 32'h2);
        check_routes("coincide_old_mode", 4'b0001, 3'h0, 3'h0);
        check_val("value_lag", 32'(value), 32'h1111);
        tick();
        check_val("stop_value", 32'(value), 32'h2222);
        pulse_mode();
        check_val("mode_cook", 32'(mode), 32'h4);
        tick();
        check_val("cook_value", 32'(value), 32'h3333);
        pulse_mode();
        check_val("mode_watch", 32'(mode), 32'h1);
        tick();
        check_val("watch_again", 32'(value), 32'h1111);

        // Stopwatch routing
        pulse_mode();
        tick();
        press_pe(4'b0100);
        check_routes("stopw_rt", 4'h0, 3'b100, 3'h0);
        tick();
        check_routes("stopw_rt_end", 4'h0, 3'h0, 3'h0);
        press_pe(4'b1000);
        check_routes("stopw_drop3", 4'h0, 3'h0, 3'h0);

        // Cook routing and alarm
        pulse_mode();
        check_val("mode_cook2", 32'(mode), 32'h4);
        press_pe(4'b0110);
        check_routes("cook_rt", 4'h0, 3'h0, 3'b110);
        cook_alarm = 1'b1;
        tick();
        check_val("alarm_enter", 32'(alarm_active), 32'h1);
        check_val("alarm_mode",  32'(mode), 32'h4);
        check_val("alarm_blank0", 32'(fnd_blank), 32'h0);
        tick();
        check_val("alarm_value", 32'(value), 32'h3333);
        wait_blank(1'b1, 40, n);
        check_val("blink_first_seen", 32'(n <= 40), 32'h1);
        wait_blank(1'b0, 40, n);
        check_val("blink_period_a", 32'(n), 32'd30);
        wait_blank(1'b1, 40, n);
        check_val("blink_period_b", 32'(n), 32'd30);
        cook_alarm = 1'b0;
        tick();
        check_val("alarm_hold_on_fall", 32'(alarm_active), 32'h1);
        press_pe(4'b0001);
        check_val("ack_pulse", 32'(alarm_ack), 32'h1);
        check_val("alarm_exit", 32'(alarm_active), 32'h0);
        check_val("exit_mode_cook", 32'(mode), 32'h4);
        check_val("exit_blank", 32'(fnd_blank), 32'h0);
        check_routes("dismiss_swallow", 4'h0, 3'h0, 3'h0);
        tick();
        check_val("ack_one_clk", 32'(alarm_ack), 32'h0);
        check_routes("dismiss_swallow2", 4'h0, 3'h0, 3'h0);

        // Alarm edge coincident with mode press in STOPW
        pulse_mode();
        pulse_mode();
        check_val("mode_stopw2", 32'(mode), 32'h2);
        cook_alarm = 1'b1;
        btn_mode   = 1'b1;
        tick();
        btn_mode = 1'b0;
        check_val("edge_beats_mode", 32'(alarm_active), 32'h1);
        cook_alarm = 1'b0;
        tick();
        cook_alarm = 1'b1;
        tick();
        check_val("reedge_in_alarm", 32'(alarm_active), 32'h1);
        pulse_mode();
        check_val("ack_by_mode", 32'(alarm_ack), 32'h1);
        check_val("return_stopw", 32'(mode), 32'h2);
        check_routes("mode_dismiss_swallow", 4'h0, 3'h0, 3'h0);
        cook_alarm = 1'b0;
        tick();

        // Inactivity behaviour in COOK, then STOPW while running
        pulse_mode();
        check_val("mode_cook3", 32'(mode), 32'h4);
`ifdef AUTO_RETURN_EN
        n = 0;
        while (mode !== 3'b001 && n < 250) begin
            tick();
            n++;
        end
        check_val("idle_return", 32'(mode), 32'h1);
        check_val("idle_not_early", 32'(n >= 190), 32'h1);
        pulse_mode();
        stopw_run = 1'b1;
        repeat (400) tick();
        check_val("idle_run_hold", 32'(mode), 32'h2);
        stopw_run = 1'b0;
`else
        repeat (250) tick();
        check_val("no_idle_return", 32'(mode), 32'h4);
`endif

        // Reset during alarm
        cook_alarm = 1'b1;
        tick();
        check_val("alarm_again", 32'(alarm_active), 32'h1);
        wait_blank(1'b1, 40, n);
        check_val("blank_before_rst", 32'(fnd_blank), 32'h1);
        cook_alarm = 1'b0;
        reset_p    = 1'b1;
        btn_pe     = 4'b0011;
        tick();
        reset_p = 1'b0;
        btn_pe  = 4'b0000;
        check_val("mid_rst_mode",  32'(mode), 32'h1);
        check_val("mid_rst_alarm", 32'(alarm_active), 32'h0);
        check_val("mid_rst_blank", 32'(fnd_blank), 32'h0);
        check_val("mid_rst_value", 32'(value), 32'h0);
        check_val("mid_rst_ack",   32'(alarm_ack), 32'h0);
        check_routes("mid_rst", 4'h0, 3'h0, 3'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
